// File: rtl/regbank_wr_ctrl_pkg.sv
//==============================================================================
// Module  : regbank_pkg
// Brief   : Shared sizes and FSM encoding for the register-bank write controller.
// Revision: 1.0
//==============================================================================
`default_nettype none

package regbank_pkg;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regbank_wr_ctrl_rr_arbiter.sv
//==============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin grant; search starts at ptr_i.
// Revision: 1.0
//==============================================================================
`default_nettype none

module rr_arbiter
    import regbank_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            // Wrap ptr+k into 0..NREQ-1 without relying on power-of-two NREQ.
            sum = {1'b0, ptr_i} + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            idx = sum[PW-1:0];
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/regbank_wr_ctrl.sv
//==============================================================================
// Module  : regbank_wr_ctrl
// Brief   : Round-robin write arbiter for a register bank with a zero-fill
//           sequence. Option macro: REGBANK_WR_CTRL_R0_PROTECT_EN (register 0
//           read-only: writes to it are accepted and dropped, clear skips it).
// Revision: 1.0
//==============================================================================
`default_nettype none

module regbank_wr_ctrl
    import regbank_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = regbank_pkg::AW,
    parameter int DW   = regbank_pkg::DW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              write,
    output logic [AW-1:0]     dr,
    output logic [DW-1:0]     wrdata
);

    localparam int PW = idx_width(NREQ);

`ifdef REGBANK_WR_CTRL_R0_PROTECT_EN
    localparam logic          c_r0_protect = 1'b1;
    localparam logic [AW-1:0] c_clr_first  = AW'(1);
`else
    localparam logic          c_r0_protect = 1'b0;
    localparam logic [AW-1:0] c_clr_first  = '0;
`endif
    localparam logic [AW-1:0] c_clr_last   = AW'(NREG - 1);

    state_e          state_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   ptr_d;
    logic            write_q;
    logic [AW-1:0]   dr_q;
    logic [DW-1:0]   wrdata_q;
    logic            busy_q;

    logic [NREQ-1:0] grant;
    logic            arb_en;
    logic            xfer;
    logic            wr_ok;
    logic [PW-1:0]   gidx;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_arbiter (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    // A pending clear wins over any requester in the same cycle.
    assign arb_en    = reset && (state_q == ST_ARB) && !clr_start;
    assign req_ready = arb_en ? grant : '0;
    assign xfer      = |(req_valid & req_ready);

    always_comb begin
        gidx     = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gidx     = PW'(i);
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    assign ptr_d = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
    assign wr_ok = xfer && !(c_r0_protect && (sel_addr == '0));

    // dr_q doubles as the clear step counter while in ST_CLEAR.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_ARB;
            ptr_q    <= '0;
            write_q  <= 1'b0;
            dr_q     <= '0;
            wrdata_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_ARB: begin
                    if (clr_start) begin
                        state_q  <= ST_CLEAR;
                        busy_q   <= 1'b1;
                        write_q  <= 1'b1;
                        dr_q     <= c_clr_first;
                        wrdata_q <= '0;
                    end else begin
                        write_q <= wr_ok;
                        if (wr_ok) begin
                            dr_q     <= sel_addr;
                            wrdata_q <= sel_data;
                        end
                        if (xfer) begin
                            ptr_q <= ptr_d;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (dr_q == c_clr_last) begin
                        state_q <= ST_ARB;
                        busy_q  <= 1'b0;
                        write_q <= 1'b0;
                    end else begin
                        dr_q    <= dr_q + 1'b1;
                        write_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_ARB;
                    write_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign write    = write_q;
    assign dr       = dr_q;
    assign wrdata   = wrdata_q;
    assign clr_busy = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_regbank_wr_ctrl.sv
//==============================================================================
// Module  : tb_regbank_wr_ctrl
// Brief   : Scoreboard bench for regbank_wr_ctrl with a behavioural model.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_regbank_wr_ctrl;

    localparam int NREQ = 4;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;
`ifdef REGBANK_WR_CTRL_R0_PROTECT_EN
    localparam int NCLR = 31;
    localparam int CLR0 = 1;
    localparam bit PROT = 1'b1;
`else
    localparam int NCLR = 32;
    localparam int CLR0 = 0;
    localparam bit PROT = 1'b0;
`endif

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 clr_start;
    logic                 clr_busy;
    logic                 write;
    logic [AW-1:0]        dr;
    logic [DW-1:0]        wrdata;

    regbank_wr_ctrl #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .write     (write),
        .dr        (dr),
        .wrdata    (wrdata)
    );

    typedef struct {
        int          due;
        int          addr;
        logic [31:0] data;
    } exp_t;

    exp_t          q[$];
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    int            m_ptr    = 0;
    int            clr_begin = 1;
    int            clr_end   = 0;
    int            hold_dr   = 0;
    logic [31:0]   hold_wd   = '0;
    logic [DW-1:0] model_bank [NREG];
    logic [DW-1:0] dut_bank   [NREG];
    logic [AW-1:0] ta [NREQ];
    logic [DW-1:0] td [NREQ];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset === 1'b0) begin
            hold_dr = 0;
            hold_wd = '0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // One bench cycle: drive inputs, check ready against the model, record
    // the writes the model expects to appear on later cycles.
    task automatic tick(input logic r, input logic [NREQ-1:0] v, input logic cs);
        logic [NREQ-1:0] exp_ready;
        bit              in_clear;
        bit              found;
        int              gi;
        @(posedge clk);
        #1;
        reset     = r;
        req_valid = v;
        clr_start = cs;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW] = ta[i];
            req_data[i*DW +: DW] = td[i];
        end
        #1;
        in_clear  = (cyc >= clr_begin) && (cyc <= clr_end);
        exp_ready = '0;
        found     = 1'b0;
        gi        = 0;
        if (r && !in_clear && !cs) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!found && v[(m_ptr + k) % NREQ]) begin
                    gi = (m_ptr + k) % NREQ;
                    exp_ready[gi] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        chk("req_ready", req_ready, exp_ready);
        if (!r) begin
            m_ptr = 0;
            while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
            if (in_clear) clr_end = cyc;
        end else if (!in_clear && cs) begin
            for (int j = 0; j < NCLR; j++) q.push_back('{cyc + 1 + j, CLR0 + j, 32'd0});
            clr_begin = cyc + 1;
            clr_end   = cyc + NCLR;
        end else if (found) begin
            if (!(PROT && ta[gi] == '0)) q.push_back('{cyc + 1, int'(ta[gi]), td[gi]});
            m_ptr = (gi + 1) % NREQ;
        end
    endtask

    exp_t e;
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("clr_busy", clr_busy, (cyc >= clr_begin && cyc <= clr_end));
            if (write === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write cyc=%0d actual dr=%0d wrdata=%0h expected no write", cyc, dr, wrdata);
                end else begin
                    e = q.pop_front();
                    chk("write_cycle", cyc, e.due);
                    chk("dr", dr, e.addr);
                    chk("wrdata", wrdata, e.data);
                    model_bank[e.addr] = e.data;
                    if (!$isunknown(dr)) dut_bank[dr] = wrdata;
                    hold_dr = e.addr;
                    hold_wd = e.data;
                end
            end else begin
                chk("write_idle", write, 0);
                chk("dr_hold", dr, hold_dr);
                chk("wrdata_hold", wrdata, hold_wd);
                if (q.size() > 0 && q[0].due <= cyc) begin
                    e = q.pop_front();
                    checks++;
                    failures++;
                    $display("FAIL missing_write cyc=%0d actual write=0 expected dr=%0d wrdata=%0h", cyc, e.addr, e.data);
                    model_bank[e.addr] = e.data;
                end
            end
        end
    end

    initial begin
        reset = 1'b0; req_valid = '0; clr_start = 1'b0;
        req_addr = '0; req_data = '0;
        for (int i = 0; i < NREG; i++) begin
            model_bank[i] = '0;
            dut_bank[i]   = '0;
        end
        for (int i = 0; i < NREQ; i++) begin
            ta[i] = '0;
            td[i] = '0;
        end
        repeat (3) tick(1'b0, '0, 1'b0);
        tick(1'b1, '0, 1'b0);

        ta[2] = 5'd7; td[2] = 32'd70;
        tick(1'b1, 4'b0100, 1'b0);
        tick(1'b1, '0, 1'b0);

        for (int i = 0; i < NREQ; i++) begin
            ta[i] = AW'(10 + i);
            td[i] = DW'(100 + i);
        end
        repeat (6) tick(1'b1, 4'b1111, 1'b0);

        ta[0] = 5'd3; td[0] = 32'd33;
        tick(1'b1, 4'b0001, 1'b1);
        repeat (NCLR + 2) tick(1'b1, 4'b0001, 1'b0);

        tick(1'b1, '0, 1'b1);
        repeat (10) tick(1'b1, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        repeat (4) tick(1'b1, '0, 1'b0);

        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                ta[i] = AW'($urandom);
                td[i] = $urandom;
            end
            tick(($urandom % 100) != 0, NREQ'($urandom), ($urandom % 40) == 0);
        end
        repeat (NCLR + 2) tick(1'b1, '0, 1'b0);

        for (int k = 0; k < NREG; k++) begin
            ta[k % NREQ] = AW'(k);
            td[k % NREQ] = DW'(10 * k);
            tick(1'b1, NREQ'(1 << (k % NREQ)), 1'b0);
        end
        tick(1'b1, '0, 1'b0);
        tick(1'b1, '0, 1'b1);
        repeat (NCLR + 3) tick(1'b1, '0, 1'b0);

        for (int r = 0; r < NREG; r++) begin
            chk("bank_model", dut_bank[r], model_bank[r]);
            chk("bank_zero", dut_bank[r], 0);
        end
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regbank_wr_ctrl.md
REGBANK_WR_CTRL -- requirements
Module: regbank_wr_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset; the ports are named clk and reset.
REQ-002 Parameter NREQ, default 4: number of write requesters.
REQ-003 Parameter AW, default 5: register address width (32 registers).
REQ-004 Parameter DW, default 32: register data width.
REQ-005 Port clk, input, 1: rising-edge clock.
REQ-006 Port reset, input, 1: synchronous active-low reset.
REQ-007 Port req_valid, input, NREQ: per-requester write request.
REQ-008 Port req_addr, input, NREQ*AW: packed destination register numbers; requester i occupies slice i.
REQ-009 Port req_data, input, NREQ*DW: packed write data; requester i occupies slice i.
REQ-010 Port req_ready, output, NREQ: per-requester accept, combinational, at most one bit set.
REQ-011 Port clr_start, input, 1: one-cycle pulse that starts a zero-fill of the whole bank.
REQ-012 Port clr_busy, output, 1: high while a zero-fill is in progress.
REQ-013 Port write, output, 1: bank write enable, registered.
REQ-014 Port dr, output, AW: bank destination register number, registered.
REQ-015 Port wrdata, output, DW: bank write data, registered.

Function
REQ-016 The block SHALL implement two states: ARB (arbitrate requesters) and CLEAR (zero-fill sequence).
REQ-017 In ARB, req_ready SHALL select exactly one valid requester by round-robin; after requester i is granted, priority starts at (i+1) mod NREQ.
REQ-018 A transfer occurs when req_valid[i] and req_ready[i] are both high; on the next cycle write=1, dr=req_addr[i] and wrdata=req_data[i].
REQ-019 If no transfer occurs, write SHALL be 0 on the next cycle, and dr and wrdata SHALL hold their values.
REQ-020 The round-robin pointer SHALL advance only on a transfer.
REQ-021 clr_start high in ARB SHALL move the block to CLEAR on the next cycle, with all req_ready bits 0 in that cycle; a clear request takes priority over a simultaneous write request.
REQ-022 In CLEAR, the block SHALL issue write=1, wrdata=0 and dr=0,1,...,31 on consecutive cycles, one register per cycle, then return to ARB.
REQ-023 clr_busy SHALL be high from the cycle after clr_start through the cycle carrying the last clear write.
REQ-024 In CLEAR, all req_ready bits SHALL be 0, and clr_start SHALL be ignored.
REQ-025 Bank latency is one cycle from handshake to the write strobe; throughput is one write per cycle.

Reset
REQ-026 When reset=0 at a clock edge, the block SHALL set: state=ARB, round-robin pointer=0, clear counter=0, write=0, dr=0, wrdata=0, clr_busy=0.
REQ-027 Reset asserted during CLEAR SHALL abort the sequence without completing it.
REQ-028 req_ready SHALL be all zero while reset=0.

Configuration
REQ-029 Macro REGBANK_WR_CTRL_R0_PROTECT_EN: when defined, a transfer with address 0 SHALL still be accepted (ready given, pointer advanced) but SHALL produce write=0, and the CLEAR sequence SHALL cover dr=1..31 (31 cycles).
REQ-030 When REGBANK_WR_CTRL_R0_PROTECT_EN is undefined, address 0 SHALL be written like any other register, and CLEAR SHALL take 32 cycles.

Structure
REQ-031 Package regbank_pkg SHALL hold AW, DW, NREG=32 and the ARB/CLEAR state encoding.
REQ-032 Round-robin grant logic SHALL be a sub-module named rr_arbiter (inputs request vector and pointer; output one-hot grant).

Verification
REQ-033 Reset, then requester 2 valid with addr=7, data=70 -> req_ready=0100 in the same cycle; next cycle write=1, dr=7, wrdata=70.
REQ-034 All four requesters valid continuously with distinct addresses -> grants in the order 0,1,2,3,0; one write per cycle.
REQ-035 clr_start pulse in the same cycle as req_valid=0001 -> no ready that cycle; dr=0..31 with wrdata=0 on consecutive cycles; clr_busy high for 32 cycles; request 0 served immediately after.
REQ-036 reset driven low at clear step 10 -> next cycle write=0, clr_busy=0, state=ARB; no further clear writes.
REQ-037 With REGBANK_WR_CTRL_R0_PROTECT_EN defined, requester 0 writes addr=0, data=5 -> ready=1, then write=0; a clear runs dr=1..31 in 31 cycles.
REQ-038 Write 10*k to registers 0..31, then a full clear -> reading every register returns 0 (register 0 returns 0 in both configurations).
